// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and ms-to-cycle sizing for the stopwatch blocks.
package stopwatch_pkg;

    typedef enum logic [1:0] {SW_IDLE, SW_RUN, SW_LAP, SW_PAUSE} sw_state_e;

    function automatic int ms_to_cycles(input int clk_freq, input int ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_press_timer.sv
// press_timer: saturating hold counter with a one-shot pulse when the hold reaches CYC cycles.
module press_timer #(
    parameter int CYC = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic long_evt
);

    localparam int W = $clog2(CYC + 1);
    localparam logic [W-1:0] CYC_W = W'(CYC);

    logic [W-1:0] cnt;

    if (CYC < 2) begin : g_bad_cyc
        $error("press_timer: CYC must be >= 2");
    end

    // Saturation stops the count at CYC, so the pulse cannot repeat within one press.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            long_evt <= 1'b0;
        end else begin
            cnt      <= !level ? '0 : (cnt == CYC_W) ? cnt : cnt + 1'b1;
            long_evt <= level && cnt == CYC_W - 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: Idle/Run/Lap/Pause sequencer driven by start/stop and lap/reset button levels.
// Long-press clear is built only when STOPWATCH_CTRL_LONGPRESS_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ      = 25_000_000,
    parameter int LONG_PRESS_MS = 1000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_ss,
    input  logic       btn_lr,
    output logic       run,
    output logic       lap_hold,
    output logic       clear,
    output logic [1:0] state_o
);

    localparam int LONG_CYC = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);

    sw_state_e state, state_nxt;
    logic      ss_q, lr_q, clear_q, clear_nxt;
    logic      ss_rise, lr_rise, long_evt;

    assign ss_rise = btn_ss & ~ss_q;
    assign lr_rise = btn_lr & ~lr_q;

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    press_timer #(.CYC(LONG_CYC)) u_press_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (btn_lr),
        .long_evt(long_evt)
    );
`else
    assign long_evt = 1'b0 && (LONG_CYC > 0);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= SW_IDLE;
            ss_q    <= 1'b0;
            lr_q    <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ss_q    <= btn_ss;
            lr_q    <= btn_lr;
            clear_q <= clear_nxt;
        end
    end

    // A long press outranks both rises; a lap/reset rise coinciding with start/stop is dropped.
    always_comb begin
        state_nxt = state;
        clear_nxt = 1'b0;
        if (long_evt) begin
            state_nxt = SW_IDLE;
            clear_nxt = 1'b1;
        end else if (ss_rise) begin
            state_nxt = (state == SW_RUN || state == SW_LAP) ? SW_PAUSE : SW_RUN;
        end else if (lr_rise) begin
            case (state)
                SW_RUN:   state_nxt = SW_LAP;
                SW_LAP:   state_nxt = SW_RUN;
                SW_PAUSE: begin
                    state_nxt = SW_IDLE;
                    clear_nxt = 1'b1;
                end
                default:  state_nxt = state;
            endcase
        end
    end

    always_comb begin
        run      = state == SW_RUN || state == SW_LAP;
        lap_hold = state == SW_LAP;
        clear    = clear_q;
        state_o  = state;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench for stopwatch_ctrl with CLK_FREQ=1000, LONG_PRESS_MS=5.
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_CTRL_LONGPRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif
    localparam int LC = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       run, lap_hold, clear;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int clears = 0;
    int cyc = 0;
    int clr_at = -1;

    logic [4:0] exp_q[$];
    logic [1:0] m_state = 2'd0;
    bit         m_ssq, m_lrq, m_long, m_clear;
    int         m_hold;

    stopwatch_ctrl #(.CLK_FREQ(1000), .LONG_PRESS_MS(5)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_ss  (btn_ss),
        .btn_lr  (btn_lr),
        .run     (run),
        .lap_hold(lap_hold),
        .clear   (clear),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference: hold counts consecutive high samples; the long event acts one edge after it hits LC.
    task automatic model(input bit rst, input bit ss, input bit lr);
        bit ssr, lrr, lng, nc;
        logic [1:0] ns;
        if (rst) begin
            m_state = 2'd0; m_ssq = 0; m_lrq = 0; m_hold = 0; m_long = 0; m_clear = 0;
        end else begin
            ssr = ss && !m_ssq;
            lrr = lr && !m_lrq;
            lng = LONG_EN && m_long;
            ns  = m_state;
            nc  = 1'b0;
            if (lng) begin
                ns = 2'd0; nc = 1'b1;
            end else if (ssr) begin
                ns = (m_state == 2'd1 || m_state == 2'd2) ? 2'd3 : 2'd1;
            end else if (lrr) begin
                case (m_state)
                    2'd1: ns = 2'd2;
                    2'd2: ns = 2'd1;
                    2'd3: begin ns = 2'd0; nc = 1'b1; end
                    default: ns = m_state;
                endcase
            end
            m_hold  = lr ? m_hold + 1 : 0;
            m_long  = (m_hold == LC);
            m_state = ns;
            m_clear = nc;
            m_ssq   = ss;
            m_lrq   = lr;
        end
        exp_q.push_back({m_state, m_state == 2'd1 || m_state == 2'd2, m_state == 2'd2, m_clear});
    endtask

    task automatic step(input bit ss, input bit lr);
        logic [4:0] e;
        btn_ss = ss;
        btn_lr = lr;
        model(!reset_n, ss, lr);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("out", {27'd0, state_o, run, lap_hold, clear}, {27'd0, e});
        if (clear) begin
            clears++;
            if (clr_at < 0) clr_at = cyc;
        end
        cyc++;
    endtask

    task automatic to_run();
        for (int i = 0; i < 4 && m_state != 2'd1; i++) begin
            step(1, 0);
            step(0, 0);
        end
    endtask

    initial begin
        #1;
        step(0, 0);
        step(0, 0);
        check("rst_state", state_o, 0);
        check("rst_outs", {run, lap_hold, clear}, 0);
        reset_n = 1'b1;
        // start, then stop
        step(1, 0);
        check("t1_run", run, 1);
        check("t1_state", state_o, 1);
        step(1, 0);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        check("t1_pause_run", run, 0);
        check("t1_pause", state_o, 3);
        step(0, 0);
        // lap and back
        step(1, 0);
        step(0, 0);
        clears = 0;
        step(0, 1);
        check("t2_lap", {lap_hold, state_o}, {1'b1, 2'd2});
        step(0, 1);
        step(0, 0);
        step(0, 1);
        check("t2_unlap", {lap_hold, state_o}, {1'b0, 2'd1});
        step(0, 1);
        step(0, 0);
        check("t2_noclear", clears, 0);
        // clear from pause
        step(1, 0);
        step(0, 0);
        clears = 0;
        step(0, 1);
        check("t3_clear", {clear, run, state_o}, {1'b1, 1'b0, 2'd0});
        step(0, 1);
        check("t3_clear_drop", clear, 0);
        step(0, 0);
        check("t3_one_clear", clears, 1);
        // long press from run
        to_run();
        clears = 0; cyc = 0; clr_at = -1;
        for (int i = 0; i < 10; i++) begin
            step(0, 1);
            if (i == 0) check("t4_lap_first", state_o, 2);
        end
        check("t4_clears", clears, LONG_EN ? 1 : 0);
        check("t4_clear_at", clr_at, LONG_EN ? LC : -1);
        check("t4_end_state", state_o, LONG_EN ? 0 : 2);
        step(0, 0);
        // simultaneous rises, then reset mid-hold
        to_run();
        step(1, 1);
        check("t5_simul", state_o, 3);
        step(0, 0);
        to_run();
        step(0, 1);
        step(0, 1);
        step(0, 1);
        reset_n = 1'b0;
        step(0, 1);
        check("t5_reset", {state_o, run, lap_hold, clear}, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) step(0, 1);
        step(0, 0);
        // long hold 20 cycles
        to_run();
        clears = 0;
        for (int i = 0; i < 20; i++) step(0, 1);
        check("t6_clears", clears, LONG_EN ? 1 : 0);
        check("t6_state", state_o, LONG_EN ? 0 : 2);
        step(0, 0);
        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            reset_n = ($urandom_range(0, 49) != 0);
            step(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 2) != 0));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
